// File: rtl/iod_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// iod_delay_line_ctrl
// Sequencer for one PolarFire IOD dynamic delay line. Runs LOAD, INC, DEC and
// SET (move to an absolute tap) commands as paced single-tap MOVE pulses,
// tracks the current tap and reports saturation / out-of-range as errors.
//
// Ports
//   i_fab_clk                  fabric clock, rising edge
//   i_sync_rst                 synchronous active-high reset
//   i_cmd_valid / o_cmd_ready  command handshake (ready only in IDLE)
//   i_cmd_op                   00 LOAD, 01 INC, 10 DEC, 11 SET
//   i_cmd_arg                  INC/DEC step count or SET target tap
//   o_done / o_err             1-cycle completion pulse, error qualifier
//   o_tap_val                  tracked current tap
//   o_delay_line_move          one-tap move strobe to the IOD
//   o_delay_line_direction     1 = increment, 0 = decrement
//   o_delay_line_load          reload strobe to the IOD
//   i_delay_line_out_of_range  IOD end-stop indication
//   o_state                    current FSM state (debug)
//
// Handshake: a command is taken in the cycle where i_cmd_valid and
// o_cmd_ready are both high; op and arg are captured on that edge, so the
// requester may change them afterwards. i_cmd_valid is ignored elsewhere.
// -----------------------------------------------------------------------------
module iod_delay_line_ctrl #(
    parameter int NUM_TAPS      = 128,
    parameter int LOAD_TAP_VAL  = 1,
    parameter int MOVE_GAP      = 4,
    parameter int SETTLE_CYCLES = 8,
    localparam int TAP_W        = $clog2(NUM_TAPS)
) (
    input  logic             i_fab_clk,
    input  logic             i_sync_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [TAP_W-1:0] i_cmd_arg,
    output logic             o_done,
    output logic             o_err,
    output logic [TAP_W-1:0] o_tap_val,
    output logic             o_delay_line_move,
    output logic             o_delay_line_direction,
    output logic             o_delay_line_load,
    input  logic             i_delay_line_out_of_range,
    output logic [2:0]       o_state
);

    localparam int CNT_MAX = (MOVE_GAP > SETTLE_CYCLES) ? MOVE_GAP : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_INIT_LOAD = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_MOVE      = 3'd3,
        S_GAP       = 3'd4,
        S_SETTLE    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_report;   // 0 until the first accepted command: hides the reset-time DONE
    logic             r_err;
    logic             w_err_set;
    logic             w_at_end;
    logic             w_arg_ok;
    logic             w_set_up;
    logic [TAP_W-1:0] w_set_diff;

    always_comb begin
        w_next       = r_state;
        w_err_set    = 1'b0;
        // The next pulse in the current direction would leave the tap range.
        w_at_end     = r_dir ? (r_tap == TAP_W'(NUM_TAPS - 1)) : (r_tap == '0);
        w_arg_ok     = (32'(i_cmd_arg) < 32'(NUM_TAPS));
        w_set_up     = (i_cmd_arg > r_tap);
        w_set_diff   = w_set_up ? (i_cmd_arg - r_tap) : (r_tap - i_cmd_arg);

        unique case (r_state)
            S_INIT_LOAD: w_next = S_SETTLE;
            S_IDLE: begin
                if (i_cmd_valid) begin
                    unique case (i_cmd_op)
                        2'b00: w_next = S_INIT_LOAD;
                        2'b01,
                        2'b10: w_next = S_SETUP;
                        2'b11: begin
                            if (!w_arg_ok) begin
                                w_next    = S_DONE;
                                w_err_set = 1'b1;
                            end else if (i_cmd_arg == r_tap) begin
                                w_next = S_SETTLE;
                            end else begin
                                w_next = S_SETUP;
                            end
                        end
                    endcase
                end
            end
            S_SETUP: begin
                if (r_rem == '0) begin
                    w_next = S_SETTLE;
                end else if (w_at_end) begin
                    w_next    = S_SETTLE;
                    w_err_set = 1'b1;
                end else begin
                    w_next = S_MOVE;
                end
            end
            // After the final pulse skip the gap and start settling at once.
            S_MOVE: w_next = (r_rem == TAP_W'(1)) ? S_SETTLE : S_GAP;
            S_GAP: begin
                if (i_delay_line_out_of_range) begin
                    w_next    = S_SETTLE;
                    w_err_set = 1'b1;
                end else if (r_cnt == '0) begin
                    if (w_at_end) begin
                        w_next    = S_SETTLE;
                        w_err_set = 1'b1;
                    end else begin
                        w_next = S_MOVE;
                    end
                end
            end
            S_SETTLE: if (r_cnt == '0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_INIT_LOAD;
        endcase
    end

    always_ff @(posedge i_fab_clk) begin
        if (i_sync_rst) begin
            r_state  <= S_INIT_LOAD;
            r_tap    <= TAP_W'(LOAD_TAP_VAL);
            r_rem    <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_report <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE) begin
                r_err <= w_err_set;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end

            if (r_state == S_IDLE && i_cmd_valid) begin
                r_report <= 1'b1;
                unique case (i_cmd_op)
                    2'b00: r_tap <= TAP_W'(LOAD_TAP_VAL);
                    2'b01: begin r_dir <= 1'b1; r_rem <= i_cmd_arg; end
                    2'b10: begin r_dir <= 1'b0; r_rem <= i_cmd_arg; end
                    2'b11: begin
                        if (w_arg_ok && (i_cmd_arg != r_tap)) begin
                            r_dir <= w_set_up;
                            r_rem <= w_set_diff;
                        end
                    end
                endcase
            end else if (r_state == S_MOVE) begin
                r_tap <= r_dir ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));
                r_rem <= r_rem - TAP_W'(1);
            end

            // One down-counter serves both the inter-pulse gap and settling.
            if (w_next == S_GAP && r_state != S_GAP) begin
                r_cnt <= CNT_W'(MOVE_GAP - 2);
            end else if (w_next == S_SETTLE && r_state != S_SETTLE) begin
                r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_cmd_ready            = (r_state == S_IDLE);
    assign o_delay_line_move      = (r_state == S_MOVE);
    // Gated by reset so LOAD stays low while reset holds the FSM in INIT_LOAD.
    assign o_delay_line_load      = (r_state == S_INIT_LOAD) && !i_sync_rst;
    assign o_done                 = (r_state == S_DONE) && r_report;
    assign o_err                  = (r_state == S_DONE) && r_report && r_err;
    assign o_delay_line_direction = r_dir;
    assign o_tap_val              = r_tap;
    assign o_state                = r_state;

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iod_delay_line_ctrl
// Bench for iod_delay_line_ctrl with a 100-tap line, so that SET targets past
// the last tap are representable. The reference model works per command:
// pulse count, final tap, error and DONE latency from plain arithmetic.
// -----------------------------------------------------------------------------
module tb_iod_delay_line_ctrl;

    localparam int N     = 100;
    localparam int LTAP  = 1;
    localparam int G     = 4;
    localparam int S     = 8;
    localparam int TAP_W = $clog2(N);

    typedef struct packed {
        logic [15:0] lat;
        logic [6:0]  tap;
        logic        err;
        logic [7:0]  pulses;
        logic        dir;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_op;
    logic [TAP_W-1:0] i_cmd_arg;
    logic             o_done;
    logic             o_err;
    logic [TAP_W-1:0] o_tap_val;
    logic             o_move;
    logic             o_dir;
    logic             o_load;
    logic             i_oor;
    logic [2:0]       o_state;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   m_tap = LTAP;

    iod_delay_line_ctrl #(
        .NUM_TAPS(N), .LOAD_TAP_VAL(LTAP), .MOVE_GAP(G), .SETTLE_CYCLES(S)
    ) dut (
        .i_fab_clk(clk),
        .i_sync_rst(rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op),
        .i_cmd_arg(i_cmd_arg),
        .o_done(o_done),
        .o_err(o_err),
        .o_tap_val(o_tap_val),
        .o_delay_line_move(o_move),
        .o_delay_line_direction(o_dir),
        .o_delay_line_load(o_load),
        .i_delay_line_out_of_range(i_oor),
        .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Pulses are limited by the step count, by the room left before an end
    // stop, and by an out-of-range indication raised after pulse k (k=0: never).
    function automatic exp_t predict(input logic [1:0] op, input int arg, input int k);
        exp_t e;
        bit   up;
        int   steps, room, p;
        bit   moves;
        e     = '0;
        up    = 1'b0;
        steps = 0;
        moves = 1'b0;
        case (op)
            2'b00: begin m_tap = LTAP; e.lat = 16'd10; end
            2'b11: begin
                if (arg >= N) begin
                    e.lat = 16'd1; e.err = 1'b1;
                end else if (arg == m_tap) begin
                    e.lat = 16'd9;
                end else begin
                    up = (arg > m_tap); steps = up ? arg - m_tap : m_tap - arg; moves = 1'b1;
                end
            end
            default: begin
                up = (op == 2'b01); steps = arg;
                if (steps == 0) e.lat = 16'd10;
                else moves = 1'b1;
            end
        endcase
        if (moves) begin
            room = up ? (N - 1 - m_tap) : m_tap;
            p = steps;
            if (room < p) p = room;
            if (k > 0 && k < p) p = k;
            if (p == steps) begin
                e.lat = 16'(2 + (p - 1) * G + 1 + S);
            end else if (k > 0 && p == k) begin
                e.lat = 16'(2 + (p - 1) * G + 2 + S); e.err = 1'b1;
            end else begin
                e.lat = 16'(2 + p * G + S); e.err = 1'b1;
            end
            m_tap    = up ? m_tap + p : m_tap - p;
            e.pulses = 8'(p);
            e.dir    = up;
        end
        e.tap = 7'(m_tap);
        return e;
    endfunction

    // ---------------- driver ----------------
    // k > 0 raises OUT_OF_RANGE right after the k-th pulse of this command.
    // stop_after > 0 returns at the stop_after-th pulse without expecting DONE.
    task automatic issue(input logic [1:0] op, input int arg, input int k, input int stop_after);
        int  seen;
        bit  ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (o_cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        if (stop_after == 0) exp_q.push_back(predict(op, arg, k));
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_arg   = TAP_W'(arg);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'($urandom);
        i_cmd_arg   = TAP_W'($urandom);
        seen = 0;
        ok   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (o_move) begin
                seen++;
                if (k > 0 && seen == k) i_oor = 1'b1;
                if (stop_after > 0 && seen == stop_after) begin ok = 1'b1; break; end
            end
            if (o_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        i_oor = 1'b0;
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    // Checks the post-reset sequence: LOAD in the first cycle, READY at cycle 10.
    task automatic check_release;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) chk("rel_move_low", int'(o_move), 0);
            chk("rel_load", int'(o_load), (k == 0) ? 1 : 0);
            chk("rel_ready", int'(o_cmd_ready), (k == 10) ? 1 : 0);
            chk("rel_done", int'(o_done), 0);
            chk("rel_tap", int'(o_tap_val), LTAP);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   acc_cyc = 0;
    int   mon_pulses = 0;
    logic first_dir = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (i_cmd_valid && o_cmd_ready) begin
                acc_cyc    = cyc;
                mon_pulses = 0;
            end
            if (o_move) begin
                if (mon_pulses == 0) first_dir = o_dir;
                else chk("dir_stable", int'(o_dir), int'(first_dir));
                mon_pulses++;
            end
            if (o_move || o_load) chk("move_load_excl", int'(o_move && o_load), 0);
            if (o_err && !o_done) chk("err_without_done", int'(o_err), 0);
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected: DONE at cycle %0d with no command pending", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency", cyc - acc_cyc, int'(e.lat));
                    chk("done_tap", int'(o_tap_val), int'(e.tap));
                    chk("done_err", int'(o_err), int'(e.err));
                    chk("pulse_count", mon_pulses, int'(e.pulses));
                    if (e.pulses != 0) chk("pulse_dir", int'(first_dir), int'(e.dir));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] op;
        int         arg, k;
        rst         = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_cmd_arg   = '0;
        i_oor       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load", int'(o_load), 0);
        chk("rst_move", int'(o_move), 0);
        chk("rst_ready", int'(o_cmd_ready), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_dir", int'(o_dir), 0);
        chk("rst_tap", int'(o_tap_val), LTAP);
        @(posedge clk);
        #1 rst = 1'b0;
        check_release();

        // Directed cases
        issue(2'b01, 3, 0, 0);    // INC 3 from 1 -> 4, DONE at T+19
        issue(2'b11, 1, 0, 0);    // SET 1 from 4 -> 3 down pulses
        issue(2'b11, 98, 0, 0);   // climb to one below the last tap
        issue(2'b01, 5, 0, 0);    // one pulse to the last tap, then saturation error
        issue(2'b01, 1, 0, 0);    // already at the end stop: no pulse, error
        issue(2'b11, 120, 0, 0);  // target past the line: DONE+ERR at T+1
        issue(2'b11, 99, 0, 0);   // SET to current tap: settle only
        issue(2'b11, 4, 0, 0);
        issue(2'b01, 10, 2, 0);   // end stop reported after 2nd pulse
        issue(2'b10, 0, 0, 0);    // zero steps
        issue(2'b11, 0, 0, 0);
        issue(2'b10, 2, 0, 0);    // below tap 0: error without a pulse
        issue(2'b00, 0, 0, 0);    // LOAD

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            arg = (op == 2'b11) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
            k   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            issue(op, arg, k, 0);
        end

        // Reset during the gap of an INC 10
        issue(2'b11, 20, 0, 0);
        issue(2'b01, 10, 0, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_tap = LTAP;
        check_release();
        issue(2'b01, 2, 0, 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
